// File: rtl/serial_subtractor_nbits_clk.sv
// ---------------------------------------------------------------------------
// serial_subtractor_nbits_clk
//
// Bit-serial unsigned subtractor. Computes a - b one bit per clock, LSB
// first, and returns the width-bit difference with the borrow-out packed
// into the MSB of the result. Companion of the bit-serial n-bit adder.
//
// Handshake (start/busy/done):
//   start_i is sampled only while idle. The cycle it is seen high, a_i and
//   b_i are captured and the operation begins. busy_o stays high from the
//   next cycle until the done cycle ends. done_o pulses high for exactly one
//   cycle, and d_o carries the new result in that cycle. start_i is ignored
//   while busy; there is no queuing, so a held start is taken again on the
//   first idle cycle.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst_n        in   1        synchronous active-low reset
//   start_i      in   1        operation request (sampled in IDLE only)
//   a_i          in   width    minuend   (sampled with start_i)
//   b_i          in   width    subtrahend (sampled with start_i)
//   busy_o       out  1        operation in progress (RUN or DONE)
//   done_o       out  1        one-cycle completion pulse
//   d_o          out  width+1  {borrow_out, difference}
//   dbg_state_o  out  2        current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module serial_subtractor_nbits_clk #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [width:0]   d_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [width-1:0] r_a;
  logic [width-1:0] r_b;
  logic [width-1:0] r_res;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic [width:0]   r_d;

  logic             w_diff;
  logic             w_bor_next;
  logic             w_last;
  logic [width-1:0] w_res_next;

  // One full-subtractor slice on the current LSBs.
  assign w_diff     = r_a[0] ^ r_b[0] ^ r_bor;
  assign w_bor_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);

  // Difference bit enters at the MSB and walks right, so after width shifts
  // bit 0 of the answer sits in the LSB. Written as a truncated shift of the
  // concatenation so width=1 needs no special case.
  assign w_res_next = width'({w_diff, r_res} >> 1);

  assign w_last     = (r_cnt == CW'(width - 1));

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_bor <= 1'b0;
      r_cnt <= '0;
      r_d   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a   <= a_i;
            r_b   <= b_i;
            r_res <= '0;
            r_bor <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_bor <= w_bor_next;
          r_cnt <= r_cnt + CW'(1);
          // d_o only ever changes here, so it never shows a partial result.
          if (w_last) r_d <= {w_bor_next, w_res_next};
        end
        default: ;
      endcase
    end
  end

  // All outputs are decodes of registers; nothing flows from inputs.
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign d_o         = r_d;
  assign dbg_state_o = r_state;

endmodule

// File: doc/serial_subtractor_nbits_clk.md
# serial_subtractor_nbits_clk

Bit-serial unsigned subtractor for the calculator datapath. It computes a − b one bit per clock, LSB first, and returns the width-bit difference with the borrow-out packed as the MSB. This is the inverse companion of the n-bit adder: the borrow-out is the counterpart of the carry-out. A start/busy/done handshake lets the calculator control FSM issue one subtraction at a time and trade latency for area.

## Interface
- width, default 8: operand width in bits; must be ≥ 1.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start_i  input  1  request; sampled only in IDLE.
- a_i  input  width  minuend; sampled together with start_i.
- b_i  input  width  subtrahend; sampled together with start_i.
- busy_o  output  1  high while an operation is in progress (RUN and DONE).
- done_o  output  1  one-cycle pulse; d_o is valid and new.
- d_o  output  width+1  result: d_o[width] is the borrow-out and d_o[width-1:0] is the difference.

## Operation
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE; the internal shift registers, borrow flop and bit counter clear.
  - d_o=0, done_o=0, busy_o=0.
  - Reset dominates start_i.
- IDLE:
  - If start_i=1, latch a_i and b_i into the operand shift registers, clear the borrow, clear the counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, one bit per cycle, using bit 0 of each operand register:
  - diff = a0 ^ b0 ^ bor.
  - bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor).
  - diff shifts into the MSB of the result shift register (shift right). Both operand registers shift right. The counter increments.
  - When the counter reaches width−1 during a RUN cycle, that is the last bit:
    - load d_o ← {bor_next, final result register};
    - go to DONE.
- DONE: done_o=1 for exactly this one cycle, then go to IDLE.
- Start handling:
  - start_i is ignored in RUN and DONE; there is no queuing.
  - A start_i held high through DONE is accepted on the first IDLE cycle.
- Result rules:
  - d_o[width-1:0] = (a − b) mod 2^width.
  - d_o[width] = 1 iff a < b, unsigned compare.
  - d_o holds its value until the next completion or reset. It never shows partial results.
- Counter width is $clog2(width+1). width=1 must work: a single RUN cycle.

## Timing
- Let E0 be the edge that samples start_i=1 in IDLE.
- busy_o rises after E0 and falls after edge E0+width+1.
- Edges E0+1 … E0+width process bits 0 … width−1.
- d_o updates and done_o rises at edge E0+width. done_o falls at E0+width+1.
- Latency from start to done is width cycles. Throughput is one operation per width+2 cycles, with start held continuously.
- Outputs are all registered, with no combinational path from inputs to outputs.
- Operand changes on a_i/b_i after E0 have no effect on the running operation.
- Reset mid-operation aborts it: no done_o pulse, d_o=0 on the next cycle, and busy_o=0.

## Test plan
- width=8, a=200, b=55, pulse start → after 8 cycles done_o=1 for one cycle, d_o=9'h091 (145, borrow 0).
- width=8, a=55, b=200 → d_o=9'h16F (borrow 1, difference 0x6F); also a=0, b=1 → d_o=9'h1FF.
- width=8, a=b=0xAA → d_o=9'h000. Then change a_i/b_i to random values mid-RUN → d_o is still 9'h000.
- Start pulsed in RUN and in DONE → ignored, exactly one done_o. Start held high continuously → completions every 10 cycles, each with correct d_o.
- rst_n=0 at cycle 4 of RUN (a=9, b=3) → busy_o=0, d_o=0, no done_o. The next start (a=9, b=3) gives d_o=9'h006.
- width=1, all four a/b combos → {borrow, diff} of 00, 01, 11, 00 for (0,0), (1,0), (0,1), (1,1). Also a random self-checking sweep at width=8 and width=16 against a − b.
